// File: rtl/pwm_seq_ctrl.sv
// Segment sequencer driving one pwm_pulse through a programmed burst table.
// Optional looping is compiled in with `define PWM_SEQ_LOOP_EN.
module pwm_seq_ctrl #(
    parameter int _RAM_WIDTH = 32,
    parameter int SEG_NUM    = 4,
    parameter int SEG_AW     = 2,
    parameter int REL_CYC    = 3
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  cfg_we,
    input  logic [SEG_AW-1:0]     cfg_addr,
    input  logic [1:0]            cfg_sel,
    input  logic [_RAM_WIDTH-1:0] cfg_wdata,
    output logic                  cfg_err,
    input  logic                  io_start,
    input  logic                  io_stop,
    input  logic                  io_loop,
    output logic                  pwm_en,
    output logic [_RAM_WIDTH-1:0] pwm_pulseWidth,
    output logic [_RAM_WIDTH-1:0] pwm_unaccessWidth,
    output logic [_RAM_WIDTH-1:0] pwm_pusle_times,
    input  logic                  pwm_pulse_valid,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_abort,
    output logic [SEG_AW-1:0]     cur_seg
);

    localparam int CNT_W = $clog2(REL_CYC + 1);
    localparam logic [CNT_W-1:0]  REL_LOAD = CNT_W'(REL_CYC - 1);
    localparam logic [SEG_AW-1:0] LAST_SEG = SEG_AW'(SEG_NUM - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state;
    logic [CNT_W-1:0]      rel_cnt;
    logic [_RAM_WIDTH-1:0] tbl_width [SEG_NUM];
    logic [_RAM_WIDTH-1:0] tbl_gap   [SEG_NUM];
    logic [_RAM_WIDTH-1:0] tbl_count [SEG_NUM];
    logic                  cfg_ok;
    logic                  loop_go;

`ifdef PWM_SEQ_LOOP_EN
    assign loop_go = io_loop;
`else
    logic unused_loop;
    assign unused_loop = io_loop;
    assign loop_go     = 1'b0;
`endif

    assign cfg_ok   = cfg_we && (state == S_IDLE) && (cfg_sel != 2'd3);
    assign seq_busy = (state != S_IDLE);
    // Done is suppressed combinationally so a stop or loop request in DONE wins.
    assign seq_done = (state == S_DONE) && !io_stop && !loop_go;

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                tbl_width[i] <= '0;
                tbl_gap[i]   <= '0;
                tbl_count[i] <= '0;
            end
        end else if (cfg_ok) begin
            case (cfg_sel)
                2'd0:    tbl_width[cfg_addr] <= cfg_wdata;
                2'd1:    tbl_gap[cfg_addr]   <= cfg_wdata;
                2'd2:    tbl_count[cfg_addr] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state             <= S_IDLE;
            rel_cnt           <= '0;
            cur_seg           <= '0;
            pwm_en            <= 1'b0;
            pwm_pulseWidth    <= '0;
            pwm_unaccessWidth <= '0;
            pwm_pusle_times   <= '0;
            seq_abort         <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            seq_abort <= 1'b0;
            cfg_err   <= cfg_we && !cfg_ok;
            case (state)
                S_IDLE: begin
                    if (io_start && !io_stop) begin
                        cur_seg <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (io_stop) begin
                        rel_cnt <= REL_LOAD;
                        state   <= S_DRAIN;
                    end else begin
                        pwm_pulseWidth    <= tbl_width[cur_seg];
                        pwm_unaccessWidth <= tbl_gap[cur_seg];
                        pwm_pusle_times   <= tbl_count[cur_seg];
                        // A zero count marks the end of the list; continuous mode is never issued.
                        if (tbl_count[cur_seg] == '0) begin
                            state <= S_DONE;
                        end else begin
                            pwm_en <= 1'b1;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (io_stop) begin
                        pwm_en  <= 1'b0;
                        rel_cnt <= REL_LOAD;
                        state   <= S_DRAIN;
                    end else if (pwm_pulse_valid) begin
                        pwm_en  <= 1'b0;
                        rel_cnt <= REL_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (io_stop) begin
                        rel_cnt <= REL_LOAD;
                        state   <= S_DRAIN;
                    end else if (rel_cnt != '0) begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end else if (cur_seg == LAST_SEG) begin
                        state <= S_DONE;
                    end else begin
                        cur_seg <= cur_seg + 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (io_stop) begin
                        rel_cnt <= REL_LOAD;
                        state   <= S_DRAIN;
                    end else if (loop_go) begin
                        cur_seg <= '0;
                        state   <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (rel_cnt != '0) begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end else begin
                        seq_abort <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: directed tables, hand sequences and randomized runs
// against a segment-level trace model; a small pwm_pulse stand-in answers pwm_en.
module tb_pwm_seq_ctrl;

    localparam int REL = 3;

    logic        io_clk, io_rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr, cfg_sel;
    logic [31:0] cfg_wdata;
    logic        cfg_err;
    logic        io_start, io_stop, io_loop;
    logic        pwm_en;
    logic [31:0] pwm_pulseWidth, pwm_unaccessWidth, pwm_pusle_times;
    logic        pwm_pulse_valid;
    logic        seq_busy, seq_done, seq_abort;
    logic [1:0]  cur_seg;

    pwm_seq_ctrl dut (
        .io_clk(io_clk), .io_rst(io_rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err),
        .io_start(io_start), .io_stop(io_stop), .io_loop(io_loop),
        .pwm_en(pwm_en), .pwm_pulseWidth(pwm_pulseWidth),
        .pwm_unaccessWidth(pwm_unaccessWidth), .pwm_pusle_times(pwm_pusle_times),
        .pwm_pulse_valid(pwm_pulse_valid),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_abort(seq_abort), .cur_seg(cur_seg)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] tbl_w [4];
    logic [31:0] tbl_g [4];
    logic [31:0] tbl_c [4];
    int          k_list [8];
    int          win_idx = 0;
    int          hi_cnt = 0;
    int          k_cur = 1;
    bit          spur_en = 1'b1;
    logic [31:0] m_pw, m_gw, m_ct;
    logic [101:0] exp_q [$];

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        exp_err;
    } cfg_vec_t;

    typedef struct {
        int c0, c1, c2, c3;
        int k;
        int exp_win;
        int exp_done_idx;
        int exp_seg;
    } scen_t;

    cfg_vec_t cvec [6];
    scen_t    scen [4];

    // pwm_pulse stand-in: raises valid on the k-th enabled cycle, random noise while disabled
    always @(negedge io_clk) begin
        if (pwm_en) begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt == 1) begin
                k_cur   = (win_idx < 8) ? k_list[win_idx] : 1000;
                win_idx = win_idx + 1;
            end
            pwm_pulse_valid = (hi_cnt == k_cur);
        end else begin
            hi_cnt = 0;
            pwm_pulse_valid = spur_en && ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [101:0] mk(input logic en, input logic busy, input logic done,
                                        input logic ab, input logic [1:0] sg,
                                        input logic [31:0] pw, input logic [31:0] gw,
                                        input logic [31:0] ct);
        return {en, busy, done, ab, sg, pw, gw, ct};
    endfunction

    function automatic logic [101:0] pack_dut();
        return {pwm_en, seq_busy, seq_done, seq_abort, cur_seg,
                pwm_pulseWidth, pwm_unaccessWidth, pwm_pusle_times};
    endfunction

    task automatic wr(input logic [1:0] addr, input logic [1:0] sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = addr; cfg_sel = sel; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic prog_all();
        for (int s = 0; s < 4; s++) begin
            wr(2'(s), 2'd0, tbl_w[s]);
            wr(2'(s), 2'd1, tbl_g[s]);
            wr(2'(s), 2'd2, tbl_c[s]);
        end
    endtask

    task automatic do_reset();
        io_rst = 1'b1;
        tick();
        tick();
        io_rst = 1'b0;
        m_pw = '0; m_gw = '0; m_ct = '0;
        for (int s = 0; s < 4; s++) begin
            tbl_w[s] = '0; tbl_g[s] = '0; tbl_c[s] = '0;
        end
    endtask

    // Expected per-cycle trace from the table: each burst is LOAD, k enabled cycles,
    // REL release cycles; the list ends at a zero count or after the last entry.
    task automatic build_trace();
        int w = 0;
        exp_q.delete();
        for (int seg = 0; seg < 4; seg++) begin
            logic [1:0] sg;
            sg = 2'(seg);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, sg, m_pw, m_gw, m_ct));
            m_pw = tbl_w[seg]; m_gw = tbl_g[seg]; m_ct = tbl_c[seg];
            if (tbl_c[seg] == 0) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, sg, m_pw, m_gw, m_ct));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, sg, m_pw, m_gw, m_ct));
                return;
            end
            for (int j = 0; j < k_list[w]; j++)
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, sg, m_pw, m_gw, m_ct));
            w++;
            for (int j = 0; j < REL; j++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, sg, m_pw, m_gw, m_ct));
            if (seg == 3) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, sg, m_pw, m_gw, m_ct));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, sg, m_pw, m_gw, m_ct));
            end
        end
    endtask

    task automatic run_trace(input string nm);
        build_trace();
        win_idx = 0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            check($sformatf("%s cyc%0d", nm, i), 128'(pack_dut()), 128'(exp_q[i]));
        end
    endtask

    task automatic run_obs(output int wins, output int done_idx, output int dones,
                           output int min_low, output int first_rise, output logic [31:0] first_pw);
        int low = 0;
        logic prev_en = 1'b0;
        wins = 0; done_idx = -1; dones = 0; min_low = 1000; first_rise = -1; first_pw = '0;
        win_idx = 0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) tick();
            if (pwm_en && !prev_en) begin
                wins++;
                if (first_rise < 0) begin
                    first_rise = i;
                    first_pw   = pwm_pulseWidth;
                end
                if (wins > 1 && low < min_low) min_low = low;
            end
            low = pwm_en ? 0 : low + 1;
            prev_en = pwm_en;
            if (seq_done) begin
                dones++;
                if (done_idx < 0) done_idx = i;
            end
            if (!seq_busy) break;
        end
    endtask

    int wins, done_idx, dones, min_low, first_rise, cnt;
    logic [31:0] first_pw;
    bit ok;

    initial begin
        io_rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0;
        io_start = 1'b0; io_stop = 1'b0; io_loop = 1'b0; pwm_pulse_valid = 1'b0;
        for (int i = 0; i < 8; i++) k_list[i] = 2;

        cvec[0] = '{1'b1, 2'd0, 2'd0, 32'h0000_0005, 1'b0};
        cvec[1] = '{1'b1, 2'd1, 2'd0, 32'h0000_0009, 1'b0};
        cvec[2] = '{1'b1, 2'd3, 2'd0, 32'hFFFF_FFFF, 1'b1};
        cvec[3] = '{1'b0, 2'd3, 2'd1, 32'hFFFF_FFFF, 1'b0};
        cvec[4] = '{1'b1, 2'd2, 2'd0, 32'h0000_0001, 1'b0};
        cvec[5] = '{1'b1, 2'd3, 2'd3, 32'h0000_1234, 1'b1};

        scen[0] = '{3, 0, 0, 0, 7, 1, 12, 1};
        scen[1] = '{2, 2, 2, 2, 3, 4, 28, 3};
        scen[2] = '{0, 5, 5, 5, 2, 0, 1, 0};
        scen[3] = '{1, 5, 0, 9, 2, 2, 13, 2};

        // reset state
        tick();
        check("reset outputs", 128'(pack_dut()), 128'(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0)));
        check("reset cfg_err", 128'(cfg_err), 128'(1'b0));
        do_reset();
        check("post-reset outputs", 128'(pack_dut()), 128'(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0)));

        // table writes in IDLE, including reserved field
        for (int v = 0; v < 6; v++) begin
            cfg_we = cvec[v].we; cfg_sel = cvec[v].sel; cfg_addr = cvec[v].addr; cfg_wdata = cvec[v].data;
            tick();
            cfg_we = 1'b0;
            check($sformatf("cfg_err vec%0d", v), 128'(cfg_err), 128'(cvec[v].exp_err));
        end
        tbl_w[0] = 32'd5; tbl_g[0] = 32'd9; tbl_c[0] = 32'd1;
        k_list[0] = 2;
        run_trace("cfg readback");

        // directed segment scenarios
        for (int n = 0; n < 4; n++) begin
            tbl_c[0] = 32'(scen[n].c0); tbl_c[1] = 32'(scen[n].c1);
            tbl_c[2] = 32'(scen[n].c2); tbl_c[3] = 32'(scen[n].c3);
            for (int s = 0; s < 4; s++) begin
                tbl_w[s] = 32'(100 + 8 * n + s);
                tbl_g[s] = 32'(200 + 8 * n + s);
            end
            prog_all();
            for (int i = 0; i < 8; i++) k_list[i] = scen[n].k;
            run_obs(wins, done_idx, dones, min_low, first_rise, first_pw);
            check($sformatf("scen%0d windows", n), 128'(wins), 128'(scen[n].exp_win));
            check($sformatf("scen%0d done cycle", n), 128'(done_idx), 128'(scen[n].exp_done_idx));
            check($sformatf("scen%0d done count", n), 128'(dones), 128'(1));
            check($sformatf("scen%0d cur_seg", n), 128'(cur_seg), 128'(scen[n].exp_seg));
            if (scen[n].exp_win > 0) begin
                check($sformatf("scen%0d first enable", n), 128'(first_rise), 128'(1));
                check($sformatf("scen%0d first width", n), 128'(first_pw), 128'(tbl_w[0]));
            end
            if (scen[n].exp_win > 1)
                check($sformatf("scen%0d low gap>=REL", n), 128'(min_low >= REL), 128'(1));
            tick();
        end

        // stop mid-RUN of seg1, with a rejected write during RUN
        for (int s = 0; s < 4; s++) tbl_c[s] = 32'd2;
        prog_all();
        for (int i = 0; i < 8; i++) k_list[i] = 50;
        win_idx = 0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        ok = 1'b0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            if (cur_seg == 2'd1 && pwm_en) begin
                ok = 1'b1;
                break;
            end
            if (seq_done) dones++;
            tick();
        end
        check("reach seg1 run", 128'(ok), 128'(1'b1));
        wr(2'd0, 2'd0, 32'hDEAD_BEEF);
        check("cfg_err in run", 128'(cfg_err), 128'(1'b1));
        tick();
        check("cfg_err one pulse", 128'(cfg_err), 128'(1'b0));
        io_stop = 1'b1;
        tick();
        io_stop = 1'b0;
        check("stop en/busy/abort", 128'({pwm_en, seq_busy, seq_abort}), 128'(3'b010));
        tick();
        check("drain 1", 128'({seq_busy, seq_abort}), 128'(2'b10));
        tick();
        check("drain 2", 128'({seq_busy, seq_abort, seq_done}), 128'(3'b100));
        tick();
        check("abort on idle", 128'({seq_busy, seq_abort}), 128'(2'b01));
        tick();
        check("abort one pulse", 128'(seq_abort), 128'(1'b0));
        check("no done on stop", 128'(dones), 128'(0));

        // table untouched by the rejected write
        for (int i = 0; i < 8; i++) k_list[i] = 2;
        run_obs(wins, done_idx, dones, min_low, first_rise, first_pw);
        check("readback after run write", 128'(first_pw), 128'(tbl_w[0]));
        check("readback windows", 128'(wins), 128'(4));

        // stop has priority over start in IDLE
        io_start = 1'b1; io_stop = 1'b1;
        tick();
        io_start = 1'b0; io_stop = 1'b0;
        check("stop beats start", 128'(seq_busy), 128'(1'b0));

        // stop in DONE beats done
        tbl_c[0] = 32'd0;
        wr(2'd0, 2'd2, 32'd0);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        tick();
        check("done reached", 128'(seq_done), 128'(1'b1));
        io_stop = 1'b1;
        #1;
        check("stop suppresses done", 128'(seq_done), 128'(1'b0));
        tick();
        io_stop = 1'b0;
        tick();
        tick();
        tick();
        check("abort from done", 128'({seq_busy, seq_abort, pwm_en}), 128'(3'b010));
        tick();

`ifdef PWM_SEQ_LOOP_EN
        // loop over two segments, then let the second pass finish
        tbl_c[0] = 32'd1; tbl_c[1] = 32'd1; tbl_c[2] = 32'd0; tbl_c[3] = 32'd0;
        prog_all();
        for (int i = 0; i < 8; i++) k_list[i] = 2;
        win_idx = 0;
        io_loop = 1'b1;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        wins = 0; dones = 0; cnt = 0; ok = 1'b0;
        begin
            logic prev_en = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (i > 0) tick();
                if (pwm_en && !prev_en) begin
                    wins++;
                    if (wins == 3) begin
                        check("loop restart seg", 128'(cur_seg), 128'(2'd0));
                        io_loop = 1'b0;
                    end
                end
                prev_en = pwm_en;
                if (seq_done) begin
                    dones++;
                    ok = 1'b1;
                    break;
                end
                if (!seq_busy) cnt++;
            end
        end
        check("loop done seen", 128'(ok), 128'(1'b1));
        check("loop windows", 128'(wins), 128'(4));
        check("loop busy held", 128'(cnt), 128'(0));
        tick();
`endif

        // randomized runs against the trace model
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int s = 0; s < 4; s++) begin
                tbl_w[s] = $urandom;
                tbl_g[s] = $urandom;
                tbl_c[s] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            end
            prog_all();
            for (int i = 0; i < 8; i++) k_list[i] = $urandom_range(1, 6);
            run_trace($sformatf("rand%0d", r));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
